dwconv_param_streamer: RTL and testbench

Parameter feeder for the MixFFN depthwise-conv stage. It is the transmitting end of the `in_valid_dwconv` / `weight_conv` / `bias` interface.
- Preloaded once through a word-serial load port.
- Each cycle the FC1 stage raises `out_valid_fc1`, it returns one channel's 3×3 kernel and bias one cycle later.
- It replaces the bench-side parameter driver so that the full accelerator runs standalone.

---
 rtl/mixffn_pkg.sv | 29 ++
 rtl/dwconv_param_streamer_bank.sv | 46 ++++
 rtl/dwconv_param_streamer.sv | 203 ++++++++++++++++++++
 tb/tb_dwconv_param_streamer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mixffn_pkg.sv
// -----------------------------------------------------------------------------
// mixffn_pkg
// Shared constants and types for the MixFFN depthwise-conv parameter path.
//   CHANNELS    : depthwise channels (channel counter wraps here)
//   K_TAPS      : kernel taps per channel (3x3)
//   W_WIDTH     : bits per weight tap and per bias
//   LOAD_WORDS  : words in one full parameter load (weights then biases)
//   param_state_t  : streamer FSM states
//   dwconv_param_t : one channel's kernel plus bias, tap j at weight[j]
// -----------------------------------------------------------------------------
package mixffn_pkg;

   localparam int CHANNELS   = 256;
   localparam int K_TAPS     = 9;
   localparam int W_WIDTH    = 16;
   localparam int LOAD_WORDS = CHANNELS * (K_TAPS + 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      READY  = 2'd1,
      STREAM = 2'd2
   } param_state_t;

   typedef struct packed {
      logic [K_TAPS-1:0][W_WIDTH-1:0] weight;
      logic [W_WIDTH-1:0]             bias;
   } dwconv_param_t;

endpackage

// File: rtl/dwconv_param_streamer_bank.sv
// -----------------------------------------------------------------------------
// param_bank
// One parameter bank: 1 write port / 1 read port synchronous RAM with a
// registered read. The read register is the streamer's only output stage, so
// it holds its value when rd_en is low and resets to zero.
//   clk, rst          : clock, synchronous active-high reset (read reg only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read request, data appears after the next edge
//   rd_data           : registered read data
// -----------------------------------------------------------------------------
module param_bank #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Contents are deliberately not reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dwconv_param_streamer.sv
// -----------------------------------------------------------------------------
// dwconv_param_streamer
// Feeds depthwise-conv kernels and biases to the MixFFN dwconv stage. Loaded
// once through a word-serial port (weights channel-major/tap-minor, then one
// bias per channel), then returns one channel per cycle of req, one cycle
// later.
//   clk, rst        : clock, synchronous active-high reset
//   load_valid/load_data : load word in; load_ready high while loading
//   load_done       : all parameter words stored
//   reload          : pulse in READY to restart loading
//   req             : one channel requested per high cycle (out_valid_fc1)
//   in_valid_dwconv : weight_conv/bias/chan_idx valid this cycle
//   weight_conv     : tap j at [j*W_WIDTH +: W_WIDTH]
//   bias, chan_idx  : bias and index of the presented channel
//   req_err         : sticky, req seen before loading finished
// -----------------------------------------------------------------------------
module dwconv_param_streamer
   import mixffn_pkg::*;
#(
   parameter int CHANNELS = mixffn_pkg::CHANNELS,
   parameter int K_TAPS   = mixffn_pkg::K_TAPS,
   parameter int W_WIDTH  = mixffn_pkg::W_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_valid,
   input  logic [W_WIDTH-1:0]            load_data,
   output logic                          load_ready,
   output logic                          load_done,
   input  logic                          reload,
   input  logic                          req,
   output logic                          in_valid_dwconv,
   output logic [K_TAPS*W_WIDTH-1:0]     weight_conv,
   output logic [W_WIDTH-1:0]            bias,
   output logic [$clog2(CHANNELS)-1:0]   chan_idx,
   output logic                          req_err
);

   localparam int WT_WORDS  = CHANNELS * K_TAPS;
   localparam int ALL_WORDS = CHANNELS * (K_TAPS + 1);
   localparam int WP_W      = $clog2(ALL_WORDS + 1);
   localparam int CC_W      = $clog2(CHANNELS);
   localparam int TAP_W     = $clog2(K_TAPS);

   localparam logic [WP_W-1:0]  WT_LAST  = WP_W'(WT_WORDS - 1);
   localparam logic [WP_W-1:0]  ALL_LAST = WP_W'(ALL_WORDS - 1);
   localparam logic [WP_W-1:0]  WT_END   = WP_W'(WT_WORDS);
   localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(CHANNELS - 1);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(K_TAPS - 1);

   param_state_t     state_q, state_d;
   logic [WP_W-1:0]  wp_q, wp_d;
   // Load-side tap/channel split of wp, kept as counters to avoid a divide by 9.
   logic [TAP_W-1:0] ld_tap_q, ld_tap_d;
   logic [CC_W-1:0]  ld_ch_q, ld_ch_d;
   logic [CC_W-1:0]  cc_q, cc_d;
   logic [CC_W-1:0]  idx_q, idx_d;
   logic             load_done_q, load_done_d;
   logic             req_err_q, req_err_d;
   logic             valid_q, valid_d;

   logic             accept;
   logic             bias_region;
   logic             rd_en;
   logic [CC_W-1:0]  cc_inc;

   assign accept      = (state_q == LOAD) && load_valid;
   assign bias_region = (wp_q >= WT_END);
   assign rd_en       = req && (state_q != LOAD);
   assign cc_inc      = (cc_q == CC_LAST) ? '0 : cc_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      ld_tap_d    = ld_tap_q;
      ld_ch_d     = ld_ch_q;
      cc_d        = cc_q;
      load_done_d = load_done_q;
      req_err_d   = req_err_q;
      valid_d     = rd_en;
      idx_d       = rd_en ? cc_q : idx_q;

      case (state_q)
         LOAD: begin
            if (req) begin
               req_err_d = 1'b1;
            end
            if (load_valid) begin
               wp_d = wp_q + 1'b1;
               if (wp_q == WT_LAST) begin
                  // Weights done: bias words start again at channel 0.
                  ld_tap_d = '0;
                  ld_ch_d  = '0;
               end else if (bias_region) begin
                  ld_ch_d = ld_ch_q + 1'b1;
               end else if (ld_tap_q == TAP_LAST) begin
                  ld_tap_d = '0;
                  ld_ch_d  = ld_ch_q + 1'b1;
               end else begin
                  ld_tap_d = ld_tap_q + 1'b1;
               end
               if (wp_q == ALL_LAST) begin
                  state_d     = READY;
                  load_done_d = 1'b1;
               end
            end
         end
         READY: begin
            // req has priority; a simultaneous reload is dropped.
            if (req) begin
               state_d = STREAM;
               cc_d    = cc_inc;
            end else if (reload) begin
               state_d     = LOAD;
               wp_d        = '0;
               ld_tap_d    = '0;
               ld_ch_d     = '0;
               cc_d        = '0;
               load_done_d = 1'b0;
            end
         end
         STREAM: begin
            if (req) begin
               cc_d = cc_inc;
            end else begin
               state_d = READY;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         wp_q        <= '0;
         ld_tap_q    <= '0;
         ld_ch_q     <= '0;
         cc_q        <= '0;
         idx_q       <= '0;
         load_done_q <= 1'b0;
         req_err_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         ld_tap_q    <= ld_tap_d;
         ld_ch_q     <= ld_ch_d;
         cc_q        <= cc_d;
         idx_q       <= idx_d;
         load_done_q <= load_done_d;
         req_err_q   <= req_err_d;
         valid_q     <= valid_d;
      end
   end

   // Weight banks: word with tap index gi lands in bank gi at its channel.
   genvar gi;
   generate
      for (gi = 0; gi < K_TAPS; gi++) begin : g_wbank
         logic wr_en_w;
         assign wr_en_w = accept && !bias_region && (ld_tap_q == TAP_W'(gi));
         param_bank #(
            .DEPTH (CHANNELS),
            .WIDTH (W_WIDTH),
            .AW    (CC_W)
         ) u_wbank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en_w),
            .wr_addr (ld_ch_q),
            .wr_data (load_data),
            .rd_en   (rd_en),
            .rd_addr (cc_q),
            .rd_data (weight_conv[gi*W_WIDTH +: W_WIDTH])
         );
      end
   endgenerate

   param_bank #(
      .DEPTH (CHANNELS),
      .WIDTH (W_WIDTH),
      .AW    (CC_W)
   ) u_bbank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && bias_region),
      .wr_addr (ld_ch_q),
      .wr_data (load_data),
      .rd_en   (rd_en),
      .rd_addr (cc_q),
      .rd_data (bias)
   );

   assign load_ready      = (state_q == LOAD);
   assign load_done       = load_done_q;
   assign in_valid_dwconv = valid_q;
   assign chan_idx        = idx_q;
   assign req_err         = req_err_q;

endmodule

// File: tb/tb_dwconv_param_streamer.sv
// Directed bench for dwconv_param_streamer: load, streaming, wrap, bursts,
// reset mid-load, reload handling and early-request error.
module tb_dwconv_param_streamer;
   import mixffn_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        load_valid = 1'b0;
   logic [W_WIDTH-1:0]          load_data = '0;
   logic                        load_ready;
   logic                        load_done;
   logic                        reload = 1'b0;
   logic                        req = 1'b0;
   logic                        in_valid_dwconv;
   logic [K_TAPS*W_WIDTH-1:0]   weight_conv;
   logic [W_WIDTH-1:0]          bias;
   logic [$clog2(CHANNELS)-1:0] chan_idx;
   logic                        req_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dwconv_param_streamer dut (
      .clk             (clk),
      .rst             (rst),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_ready      (load_ready),
      .load_done       (load_done),
      .reload          (reload),
      .req             (req),
      .in_valid_dwconv (in_valid_dwconv),
      .weight_conv     (weight_conv),
      .bias            (bias),
      .chan_idx        (chan_idx),
      .req_err         (req_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (in_valid_dwconv !== 1'b0 || weight_conv !== '0 || bias !== '0 || chan_idx !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b bias=%0h idx=%0d w=%0h, required all zero",
                  in_valid_dwconv, bias, chan_idx, weight_conv);
      end
      checks++;
      if (load_ready !== 1'b1 || load_done !== 1'b0 || req_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: ready=%0b done=%0b err=%0b, required 1 0 0",
                  load_ready, load_done, req_err);
      end
      rst = 1'b0;
      $display("reset: ready=%0b done=%0b", load_ready, load_done);
   endtask

   // Load n words of value k+off; checks load_done timing around the last word.
   task automatic load_words(input int n, input int off);
      for (int k = 0; k < n; k++) begin
         load_valid = 1'b1;
         load_data  = W_WIDTH'(k + off);
         if (k == n - 1 || k == 0) begin
            checks++;
            if (load_done !== 1'b0 || load_ready !== 1'b1) begin
               errors++;
               $display("FAIL load_pre word %0d: done=%0b ready=%0b, required 0 1", k, load_done, load_ready);
            end
         end
         step();
      end
      load_valid = 1'b0;
      checks++;
      if (n == LOAD_WORDS) begin
         if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_post: done=%0b ready=%0b, required 1 0", load_done, load_ready);
         end
      end else if (load_done !== 1'b0) begin
         errors++;
         $display("FAIL load_partial: done=%0b, required 0", load_done);
      end
      $display("load: %0d words offset %0h done=%0b", n, off, load_done);
   endtask

   // n back-to-back requests starting at channel first_ch; reload pulsed with
   // request number reload_at (negative = never).
   task automatic stream(input int n, input int first_ch, input int off, input int reload_at);
      dwconv_param_t e;
      int c;
      c = first_ch;
      for (int i = 0; i < n; i++) begin
         c = (first_ch + i) % CHANNELS;
         req    = 1'b1;
         reload = (i == reload_at);
         step();
         reload = 1'b0;
         for (int j = 0; j < K_TAPS; j++) e.weight[j] = W_WIDTH'(K_TAPS * c + j + off);
         e.bias = W_WIDTH'(CHANNELS * K_TAPS + c + off);
         checks++;
         if (in_valid_dwconv !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid ch %0d: got %0b required 1", c, in_valid_dwconv);
         end
         checks++;
         if (chan_idx !== c[$clog2(CHANNELS)-1:0]) begin
            errors++;
            $display("FAIL stream_idx: got %0d required %0d", chan_idx, c);
         end
         checks++;
         if (weight_conv !== e.weight) begin
            errors++;
            $display("FAIL stream_weight ch %0d: got %0h required %0h", c, weight_conv, e.weight);
         end
         checks++;
         if (bias !== e.bias) begin
            errors++;
            $display("FAIL stream_bias ch %0d: got %0h required %0h", c, bias, e.bias);
         end
         checks++;
         if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream_state ch %0d: done=%0b ready=%0b, required 1 0", c, load_done, load_ready);
         end
         $display("req %0d: ch=%0d bias=%0h tap0=%0h", i, chan_idx, bias, weight_conv[W_WIDTH-1:0]);
      end
      req = 1'b0;
      step();
      checks++;
      if (in_valid_dwconv !== 1'b0 || chan_idx !== c[$clog2(CHANNELS)-1:0] ||
          bias !== W_WIDTH'(CHANNELS * K_TAPS + c + off)) begin
         errors++;
         $display("FAIL stream_hold: valid=%0b idx=%0d bias=%0h, required 0 %0d %0h",
                  in_valid_dwconv, chan_idx, bias, c, CHANNELS * K_TAPS + c + off);
      end
   endtask

   task automatic test_req_before_load();
      req = 1'b1;
      step();
      req = 1'b0;
      checks++;
      if (in_valid_dwconv !== 1'b0 || req_err !== 1'b1) begin
         errors++;
         $display("FAIL early_req: valid=%0b err=%0b, required 0 1", in_valid_dwconv, req_err);
      end
      step();
      checks++;
      if (in_valid_dwconv !== 1'b0 || req_err !== 1'b1) begin
         errors++;
         $display("FAIL early_req_hold: valid=%0b err=%0b, required 0 1", in_valid_dwconv, req_err);
      end
      $display("early req: valid=%0b err=%0b", in_valid_dwconv, req_err);
   endtask

   task automatic test_rst_midload();
      load_words(1000, 0);
      checks++;
      if (req_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %0b required 1", req_err);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (req_err !== 1'b0 || load_done !== 1'b0 || load_ready !== 1'b1 || in_valid_dwconv !== 1'b0) begin
         errors++;
         $display("FAIL midload_rst: err=%0b done=%0b ready=%0b valid=%0b, required 0 0 1 0",
                  req_err, load_done, load_ready, in_valid_dwconv);
      end
      load_words(LOAD_WORDS, 'h100);
      // First streamed channel must be 0; channel 1 tap 0 reads 0x0109.
      stream(2, 0, 'h100, -1);
      checks++;
      if (weight_conv[W_WIDTH-1:0] !== 16'h0109) begin
         errors++;
         $display("FAIL ch1_tap0: got %0h required 0109", weight_conv[W_WIDTH-1:0]);
      end
   endtask

   task automatic test_reload_ready(input int off);
      reload = 1'b1;
      step();
      reload = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || load_done !== 1'b0) begin
         errors++;
         $display("FAIL reload_ready: ready=%0b done=%0b, required 1 0", load_ready, load_done);
      end
      $display("reload: ready=%0b done=%0b", load_ready, load_done);
      load_words(LOAD_WORDS, off);
   endtask

   task automatic test_burst();
      stream(64, 0, 0, -1);
      for (int i = 0; i < 190; i++) begin
         step();
         checks++;
         if (in_valid_dwconv !== 1'b0 || chan_idx !== 8'd63) begin
            errors++;
            $display("FAIL idle %0d: valid=%0b idx=%0d, required 0 63", i, in_valid_dwconv, chan_idx);
         end
      end
      stream(64, 64, 0, -1);
   endtask

   initial begin
      test_reset();
      test_req_before_load();
      test_rst_midload();
      test_reload_ready(0);
      test_burst();
      // reload mid-stream is ignored: channels 128..255 continue unbroken
      stream(128, 128, 0, 10);
      // 257th request wraps to channel 0; reload in READY with req is dropped
      stream(1, 0, 0, 0);
      checks++;
      if (weight_conv[W_WIDTH-1:0] !== 16'h0000 || bias !== 16'h0900 || load_done !== 1'b1) begin
         errors++;
         $display("FAIL wrap: tap0=%0h bias=%0h done=%0b, required 0000 0900 1",
                  weight_conv[W_WIDTH-1:0], bias, load_done);
      end
      stream(3, 1, 0, -1);
      // reload in READY restarts the channel counter
      test_reload_ready('h55);
      stream(2, 0, 'h55, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
